mpc_div_31s_10s_21_seq: RTL

//  Sequential signed divider, the inverse of the 21s x 10s -> 31 product multiplier in the MPC datapath.

---
 rtl/mpc_div_31s_10s_21_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mpc_div_31s_10s_21_seq.sv
// Sequential signed divider (31s / 10s -> 21s, saturating), radix-2 restoring on magnitudes.
// Optional remainder output r is enabled by defining MPC_DIV_REM_EN.
module mpc_div_31s_10s_21_seq #(
   parameter int unsigned DIVIDEND_W = 31,
   parameter int unsigned DIVISOR_W  = 10,
   parameter int unsigned QUOTIENT_W = 21
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] a,
   input  logic [DIVISOR_W-1:0]  b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOTIENT_W-1:0] q,
   output logic                  ovf,
   output logic                  dbz
`ifdef MPC_DIV_REM_EN
   ,
   output logic [DIVISOR_W-1:0]  r
`endif
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
   localparam int unsigned REM_W = DIVISOR_W + 1;
   localparam int unsigned SH_W  = REM_W + 1;
   localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(DIVIDEND_W - 1);
   localparam logic [DIVIDEND_W-1:0] POS_LIM   = DIVIDEND_W'((64'd1 << (QUOTIENT_W - 1)) - 64'd1);
   localparam logic [DIVIDEND_W-1:0] NEG_LIM   = DIVIDEND_W'(64'd1 << (QUOTIENT_W - 1));
   localparam logic [QUOTIENT_W-1:0] Q_MAX     = {1'b0, {(QUOTIENT_W-1){1'b1}}};
   localparam logic [QUOTIENT_W-1:0] Q_MIN     = {1'b1, {(QUOTIENT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

   state_e                  state_q, state_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
   logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
   logic [REM_W-1:0]        rem_q, rem_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sign_q, sign_d;
   logic                    asign_q, asign_d;
   logic                    zero_q, zero_d;
   logic [QUOTIENT_W-1:0]   q_q, q_d;
   logic                    ovf_q, ovf_d;
   logic                    dbz_q, dbz_d;
   logic [SH_W-1:0]         rem_sh;
`ifdef MPC_DIV_REM_EN
   logic [DIVISOR_W-1:0]    r_q, r_d;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else if (ce) begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (in_valid)             state_d = S_CALC;
         S_CALC: if (cnt_q == LAST_STEP)   state_d = S_FIX;
         S_FIX:                            state_d = S_DONE;
         S_DONE: if (out_ready)            state_d = S_IDLE;
         default:                          state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the next state so they register alongside it
   always_comb begin
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
   end

   // Datapath: latch magnitudes, shift/subtract, then sign-fix and saturate
   always_comb begin
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      asign_d = asign_q;
      zero_d  = zero_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;
`ifdef MPC_DIV_REM_EN
      r_d     = r_q;
`endif
      rem_sh  = {rem_q, dvd_q[DIVIDEND_W-1]};
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               dvd_d   = a[DIVIDEND_W-1] ? DIVIDEND_W'(0) - a : a;
               dvs_d   = b[DIVISOR_W-1]  ? DIVISOR_W'(0) - b  : b;
               rem_d   = '0;
               cnt_d   = '0;
               sign_d  = a[DIVIDEND_W-1] ^ b[DIVISOR_W-1];
               asign_d = a[DIVIDEND_W-1];
               zero_d  = (b == '0);
            end
         end
         S_CALC: begin
            // Quotient bits shift in behind the dividend bits being consumed
            if (rem_sh >= SH_W'(dvs_q)) begin
               rem_d = REM_W'(rem_sh - SH_W'(dvs_q));
               dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b1};
            end else begin
               rem_d = REM_W'(rem_sh);
               dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
         end
         S_FIX: begin
            dbz_d = zero_q;
            ovf_d = 1'b0;
            if (zero_q) begin
               q_d = asign_q ? Q_MIN : Q_MAX;
            end else if (sign_q && (dvd_q > NEG_LIM)) begin
               q_d   = Q_MIN;
               ovf_d = 1'b1;
            end else if (!sign_q && (dvd_q > POS_LIM)) begin
               q_d   = Q_MAX;
               ovf_d = 1'b1;
            end else begin
               q_d = sign_q ? QUOTIENT_W'(DIVIDEND_W'(0) - dvd_q) : QUOTIENT_W'(dvd_q);
            end
`ifdef MPC_DIV_REM_EN
            if (zero_q) begin
               r_d = '0;
            end else begin
               r_d = asign_q ? DIVISOR_W'(REM_W'(0) - rem_q) : DIVISOR_W'(rem_q);
            end
`endif
         end
         default: ;
      endcase
   end

   // Datapath and handshake registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         asign_q     <= 1'b0;
         zero_q      <= 1'b0;
         q_q         <= '0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
`ifdef MPC_DIV_REM_EN
         r_q         <= '0;
`endif
      end else if (ce) begin
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         sign_q      <= sign_d;
         asign_q     <= asign_d;
         zero_q      <= zero_d;
         q_q         <= q_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
`ifdef MPC_DIV_REM_EN
         r_q         <= r_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign q         = q_q;
   assign ovf       = ovf_q;
   assign dbz       = dbz_q;
`ifdef MPC_DIV_REM_EN
   assign r         = r_q;
`endif

endmodule
